// File: rtl/esc_pwm_gen.sv
// ESC PWM generator: captures speed/trim on a write strobe and applies the resulting pulse width at period boundaries.
// Define ESC_SLEW_EN to limit the pulse-width change per period to SLEW_STEP clocks.
module esc_pwm_gen #(
   parameter int PERIOD_W  = 18,
   parameter int MIN_CLKS  = 6250,
   parameter int SLEW_STEP = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wrt,
   input  logic [10:0] spd,
   input  logic [9:0]  off,
   output logic        pwm,
   output logic        frm,
   output logic [13:0] pulse
);

   localparam logic [13:0] MIN_P = 14'(MIN_CLKS);

   if (PERIOD_W < 15 || PERIOD_W > 20 || SLEW_STEP < 1) begin : g_bad_param
      $error("esc_pwm_gen: PERIOD_W must be 15..20 and SLEW_STEP positive");
   end

   logic [10:0]         spd_q, spd_d;
   logic [9:0]          off_q, off_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [13:0]         pulse_q, pulse_d;
   logic                pwm_q, pwm_d;
   logic                frm_q, frm_d;
   logic [13:0]         tgt;
   logic [13:0]         pulse_nxt;
   logic                boundary;

   // 3*spd formed as (spd << 1) + spd; the sum tops out at 13414, so 14 bits never overflow.
   always_comb begin
      tgt = MIN_P + {2'b00, spd_q, 1'b0} + {3'b000, spd_q} + {4'b0000, off_q};
   end

`ifdef ESC_SLEW_EN
   localparam logic signed [14:0] STEP_S = 15'(SLEW_STEP);
   localparam logic        [13:0] STEP_U = 14'(SLEW_STEP);
   logic signed [14:0] diff;

   always_comb begin
      diff = $signed({1'b0, tgt}) - $signed({1'b0, pulse_q});
      if (diff > STEP_S) begin
         pulse_nxt = pulse_q + STEP_U;
      end else if (diff < -STEP_S) begin
         pulse_nxt = pulse_q - STEP_U;
      end else begin
         pulse_nxt = tgt;
      end
   end
`else
   always_comb begin
      pulse_nxt = tgt;
   end
`endif

   // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      spd_d    = spd_q;
      off_d    = off_q;
      pulse_d  = pulse_q;
      boundary = &cnt_q;
      cnt_d    = cnt_q + PERIOD_W'(1);
      if (wrt) begin
         spd_d = spd;
         off_d = off;
      end
      // The boundary uses spd_q/off_q as they stand, so a same-cycle write lands a period later.
      if (boundary) begin
         pulse_d = pulse_nxt;
      end
      pwm_d = {{(PERIOD_W-14){1'b0}}, pulse_d} > cnt_d;
      frm_d = &cnt_d;
   end

   // NOTE: state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spd_q   <= '0;
         off_q   <= '0;
         cnt_q   <= '1;
         pulse_q <= MIN_P;
         pwm_q   <= 1'b0;
         frm_q   <= 1'b0;
      end else begin
         spd_q   <= spd_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         pwm_q   <= pwm_d;
         frm_q   <= frm_d;
      end
   end

   assign pwm   = pwm_q;
   assign frm   = frm_q;
   assign pulse = pulse_q;

endmodule

// File: tb/tb_esc_pwm_gen.sv
// Self-checking bench for esc_pwm_gen at PERIOD_W=15: random writes scored against a period-level reference model.
module tb_esc_pwm_gen;

   localparam int PW   = 15;
   localparam int PLEN = 1 << PW;
   localparam int MINC = 6250;
   localparam int STEP = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrt;
   logic [10:0] spd;
   logic [9:0]  off;
   logic        pwm;
   logic        frm;
   logic [13:0] pulse;

   esc_pwm_gen #(.PERIOD_W(PW), .MIN_CLKS(MINC), .SLEW_STEP(STEP)) dut (
      .clk   (clk),
      .rst   (rst),
      .wrt   (wrt),
      .spd   (spd),
      .off   (off),
      .pwm   (pwm),
      .frm   (frm),
      .pulse (pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [10:0] s;
      logic [9:0]  o;
   } wr_t;

   wr_t wq[$];
   int  errors = 0;
   int  checks = 0;

   // Reference model state: captured speed/trim and the pulse width of the running period.
   int mspd, moff, mpulse;

   // Measurements of one period.
   int hi_cnt, first_hi, last_hi, frm_cnt, frm_idx, bnd_pwm, start_pulse;

   function automatic int model_tgt(int s, int o);
      return MINC + 3 * s + o;
   endfunction

   function automatic int model_next(int cur, int t);
`ifdef ESC_SLEW_EN
      if (t - cur > STEP) return cur + STEP;
      if (cur - t > STEP) return cur - STEP;
      return t;
`else
      return t;
`endif
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Entered at the sample point of cnt==0; leaves at cnt==0 of the following period.
   task automatic run_period();
      int  nxt;
      wr_t w;
      hi_cnt = 0; first_hi = -1; last_hi = -1; frm_cnt = 0; frm_idx = -1; bnd_pwm = -1;
      nxt = mpulse;
      for (int c = 0; c < PLEN; c++) begin
         if (c == 0) start_pulse = int'(pulse);
         if (pwm === 1'b1) begin
            hi_cnt++;
            if (first_hi < 0) first_hi = c;
            last_hi = c;
         end
         if (frm === 1'b1) begin
            frm_cnt++;
            frm_idx = c;
         end
         if (c == PLEN - 1) begin
            bnd_pwm = int'(pwm);
            nxt = model_next(mpulse, model_tgt(mspd, moff));
         end
         wrt = 1'b0;
         if (wq.size() > 0 && wq[0].cyc == c) begin
            w    = wq.pop_front();
            wrt  = 1'b1;
            spd  = w.s;
            off  = w.o;
            mspd = int'(w.s);
            moff = int'(w.o);
         end
         step(1);
      end
      wrt    = 1'b0;
      mpulse = nxt;
   endtask

   task automatic check_period(input string name, input int exp_w);
      check({name, "_start_pulse"}, start_pulse, exp_w);
      check({name, "_width"}, hi_cnt, exp_w);
      check({name, "_first_hi"}, first_hi, 0);
      check({name, "_last_hi"}, last_hi, exp_w - 1);
      check({name, "_frm_cnt"}, frm_cnt, 1);
      check({name, "_frm_idx"}, frm_idx, PLEN - 1);
      check({name, "_bnd_pwm"}, bnd_pwm, 0);
   endtask

   initial begin
      int r1, exp_w, n;
      rst = 1'b1; wrt = 1'b0; spd = '0; off = '0;
      mspd = 0; moff = 0; mpulse = MINC;

      step(3);
      check("rst_pwm", int'(pwm), 0);
      check("rst_frm", int'(frm), 0);
      check("rst_pulse", int'(pulse), MINC);

      rst = 1'b0;
      step(1);
      check("first_pwm", int'(pwm), 1);
      check("first_frm", int'(frm), 0);

      // Period 1: full-scale write mid-pulse, random writes back-to-back, full-scale write on the boundary.
      r1 = int'($urandom_range(7000, 30000));
      wq.push_back('{3000, 11'h7FF, 10'h000});
      wq.push_back('{3001, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023))});
      wq.push_back('{r1, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023))});
      wq.push_back('{r1 + 1, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023))});
      wq.push_back('{PLEN - 1, 11'h7FF, 10'h3FF});
      exp_w = mpulse;
      run_period();
      check_period("p1", exp_w);

      // Period 2: width set by the last random write; the boundary write must not show yet.
      exp_w = mpulse;
      run_period();
      check_period("p2", exp_w);

      // Period 3: deferred full-scale write now applies; reset lands mid-pulse.
      check("p3_pulse", int'(pulse), mpulse);
      check("p3_pwm_start", int'(pwm), 1);
      step(3000);
      check("p3_pwm_mid", int'(pwm), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm", int'(pwm), 0);
      check("async_rst_pulse", int'(pulse), MINC);
      check("async_rst_frm", int'(frm), 0);
      mspd = 0; moff = 0; mpulse = MINC;
      step(2);
      check("rst_hold_pwm", int'(pwm), 0);
      rst = 1'b0;
      step(1);
      check("restart_pwm", int'(pwm), 1);
      check("restart_pulse", int'(pulse), mpulse);
      n = 0;
      while (pwm === 1'b1 && n < 20000) begin
         n++;
         step(1);
      end
      check("restart_width", n, mpulse);
      check("restart_frm", int'(frm), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
